// File: rtl/sample_modulation_azseq_pkg.sv
// Shared state encoding and code constants for the auto-zero sample sequencer.
// LO_SETTLE exists only when SAMPLE_MODULATION_AZSEQ_SETTLE_EN is defined.
package sample_modulation_azseq_pkg;

  typedef enum logic [3:0] {
    S_IDLE,
    S_PC_BOOT,
    S_PC_WAIT,
    S_HI_SEL,
    S_HI_WAIT,
    S_HI_TRIG,
    S_HI_ADC,
    S_PC_BOOT2,
    S_PC_WAIT2,
    S_LO_SEL,
`ifdef SAMPLE_MODULATION_AZSEQ_SETTLE_EN
    S_LO_SETTLE,
`endif
    S_LO_TRIG,
    S_LO_ADC
  } azseq_state_t;

  localparam logic       SW_PC_SIGNAL = 1'b1;
  localparam logic       SW_PC_BOOT   = 1'b0;
  localparam logic [3:0] AZMUX_OFF    = 4'h0;

endpackage

// File: rtl/azseq_dwell_counter.sv
// Loadable down-counter that stops at zero; used for every precharge/settle dwell.
module azseq_dwell_counter #(
  parameter int unsigned CNT_W = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_val,
  input  logic             i_count,
  output logic             o_zero
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_count && !o_zero) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/sample_modulation_azseq.sv
// HI/LO auto-zero measurement sequencer with per-channel AZ-mux codes.
// Define SAMPLE_MODULATION_AZSEQ_SETTLE_EN to add the LO settle dwell.
module sample_modulation_azseq
  import sample_modulation_azseq_pkg::*;
#(
  parameter int unsigned CLK_FREQ = 20000000,
  parameter int unsigned NCH      = 4,
  parameter int unsigned CNT_W    = 24
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic                                      az_mode,
  input  logic [NCH*4-1:0]                          azmux_hi_vals,
  input  logic [3:0]                                azmux_lo_val,
  input  logic [CNT_W-1:0]                          precharge_n,
  input  logic [CNT_W-1:0]                          settle_n,
  input  logic                                      adc_measure_valid,
  output logic                                      adc_measure_trig,
  output logic                                      sw_pc_ctl,
  output logic [3:0]                                azmux,
  output logic                                      led0,
  output logic [1:0]                                monitor,
  output logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0]  chan,
  output logic                                      hi_phase
);

  localparam int unsigned CHW = (NCH > 1) ? $clog2(NCH) : 1;

  azseq_state_t     r_state;
  logic             r_trig;
  logic             r_sw_pc;
  logic [3:0]       r_azmux;
  logic             r_led0;
  logic [1:0]       r_monitor;
  logic [CHW-1:0]   r_chan;
  logic             r_hi_phase;
  logic             r_adc_armed;

  logic             w_load;
  logic             w_count;
  logic             w_zero;
  logic [CNT_W-1:0] w_load_val;
  logic             w_wrap;
  logic [CHW-1:0]   w_chan_adv;
  logic [3:0]       w_hi_cur;
  logic [3:0]       w_hi_adv;
  logic             w_adc_done;
  logic             w_unused_cfg;

  function automatic logic [3:0] hi_code(input logic [NCH*4-1:0] vals, input logic [CHW-1:0] c);
    return vals[{c, 2'b00} +: 4];
  endfunction

  assign w_wrap       = (r_chan == CHW'(NCH - 1));
  assign w_chan_adv   = w_wrap ? '0 : r_chan + CHW'(1);
  assign w_hi_cur     = hi_code(azmux_hi_vals, r_chan);
  assign w_hi_adv     = hi_code(azmux_hi_vals, w_chan_adv);
  // The first ADC cycle never counts, so a valid left over from the trigger cycle is ignored.
  assign w_adc_done   = r_adc_armed & adc_measure_valid;
  assign w_unused_cfg = (CLK_FREQ == 0);

`ifndef SAMPLE_MODULATION_AZSEQ_SETTLE_EN
  logic w_unused_settle;
  assign w_unused_settle = ^settle_n;
`endif

  always_comb begin
    w_load     = 1'b0;
    w_count    = 1'b0;
    w_load_val = precharge_n;
    unique case (r_state)
      S_PC_BOOT, S_HI_SEL, S_PC_BOOT2: w_load = 1'b1;
      S_PC_WAIT, S_HI_WAIT, S_PC_WAIT2: w_count = 1'b1;
`ifdef SAMPLE_MODULATION_AZSEQ_SETTLE_EN
      S_LO_SEL: begin
        w_load     = 1'b1;
        w_load_val = settle_n;
      end
      S_LO_SETTLE: w_count = 1'b1;
`endif
      default: ;
    endcase
  end

  azseq_dwell_counter #(.CNT_W(CNT_W)) u_dwell (
    .clk        (clk),
    .reset      (reset),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .i_count    (w_count),
    .o_zero     (w_zero)
  );

  // Outputs are updated on the edge that enters a state, so they line up with that state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_trig      <= 1'b0;
      r_sw_pc     <= SW_PC_BOOT;
      r_azmux     <= AZMUX_OFF;
      r_led0      <= 1'b0;
      r_monitor   <= '0;
      r_chan      <= '0;
      r_hi_phase  <= 1'b0;
      r_adc_armed <= 1'b0;
    end else begin
      r_trig       <= 1'b0;
      r_monitor[1] <= 1'b0;
      unique case (r_state)
        S_IDLE:    r_state <= S_PC_BOOT;
        S_PC_BOOT: r_state <= S_PC_WAIT;
        S_PC_WAIT: if (w_zero) begin
          r_state <= S_HI_SEL;
          r_azmux <= w_hi_cur;
        end
        S_HI_SEL:  r_state <= S_HI_WAIT;
        S_HI_WAIT: if (w_zero) begin
          r_state      <= S_HI_TRIG;
          r_trig       <= 1'b1;
          r_monitor[1] <= 1'b1;
          r_sw_pc      <= SW_PC_SIGNAL;
          r_led0       <= 1'b1;
          r_hi_phase   <= 1'b1;
        end
        S_HI_TRIG: begin
          r_state     <= S_HI_ADC;
          r_adc_armed <= 1'b0;
        end
        S_HI_ADC: begin
          r_adc_armed <= 1'b1;
          if (w_adc_done) begin
            if (az_mode) begin
              r_state <= S_PC_BOOT2;
              r_sw_pc <= SW_PC_BOOT;
            end else begin
              r_state      <= S_HI_SEL;
              r_chan       <= w_chan_adv;
              r_azmux      <= w_hi_adv;
              r_monitor[0] <= r_monitor[0] ^ w_wrap;
            end
          end
        end
        S_PC_BOOT2: r_state <= S_PC_WAIT2;
        S_PC_WAIT2: if (w_zero) begin
          r_state    <= S_LO_SEL;
          r_azmux    <= azmux_lo_val;
          r_led0     <= 1'b0;
          r_hi_phase <= 1'b0;
        end
`ifdef SAMPLE_MODULATION_AZSEQ_SETTLE_EN
        S_LO_SEL:    r_state <= S_LO_SETTLE;
        S_LO_SETTLE: if (w_zero) begin
          r_state <= S_LO_TRIG;
          r_trig  <= 1'b1;
        end
`else
        S_LO_SEL: begin
          r_state <= S_LO_TRIG;
          r_trig  <= 1'b1;
        end
`endif
        S_LO_TRIG: begin
          r_state     <= S_LO_ADC;
          r_adc_armed <= 1'b0;
        end
        S_LO_ADC: begin
          r_adc_armed <= 1'b1;
          if (w_adc_done) begin
            r_state      <= S_HI_SEL;
            r_chan       <= w_chan_adv;
            r_azmux      <= w_hi_adv;
            r_monitor[0] <= r_monitor[0] ^ w_wrap;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign adc_measure_trig = r_trig;
  assign sw_pc_ctl        = r_sw_pc;
  assign azmux            = r_azmux;
  assign led0             = r_led0;
  assign monitor          = r_monitor;
  assign chan             = r_chan;
  assign hi_phase         = r_hi_phase;

endmodule

// File: tb/tb_sample_modulation_azseq.sv
// Random-stimulus bench: a phase-level model predicts every output cycle by cycle.
module tb_sample_modulation_azseq;

  localparam int unsigned NCH   = 2;
  localparam int unsigned CNT_W = 8;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             az_mode = 1'b0;
  logic [NCH*4-1:0] azmux_hi_vals = '0;
  logic [3:0]       azmux_lo_val = '0;
  logic [CNT_W-1:0] precharge_n = '0;
  logic [CNT_W-1:0] settle_n = '0;
  logic             adc_measure_valid = 1'b0;
  logic             adc_measure_trig, sw_pc_ctl, led0, hi_phase;
  logic [3:0]       azmux;
  logic [1:0]       monitor;
  logic [0:0]       chan;

  sample_modulation_azseq #(.CLK_FREQ(20000000), .NCH(NCH), .CNT_W(CNT_W)) dut (
    .clk               (clk),
    .reset             (reset),
    .az_mode           (az_mode),
    .azmux_hi_vals     (azmux_hi_vals),
    .azmux_lo_val      (azmux_lo_val),
    .precharge_n       (precharge_n),
    .settle_n          (settle_n),
    .adc_measure_valid (adc_measure_valid),
    .adc_measure_trig  (adc_measure_trig),
    .sw_pc_ctl         (sw_pc_ctl),
    .azmux             (azmux),
    .led0              (led0),
    .monitor           (monitor),
    .chan              (chan),
    .hi_phase          (hi_phase)
  );

  typedef struct packed {
    logic       trig;
    logic       sw;
    logic [3:0] az;
    logic       led;
    logic [1:0] mon;
    logic [0:0] chan;
    logic       hi;
  } outs_t;

  outs_t exp_o, got_o;
  bit    exp_on = 0;
  int    n_checks = 0, n_errors = 0;
  int    cyc = 0, d0 = 0;
  bit    dir = 0, aborted = 0, obs_on = 0;

  logic       m_sw, m_led, m_hi, m_mon0;
  logic [3:0] m_az;
  int         m_chan;

  int         trig_cyc[$];
  logic [3:0] trig_az[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign got_o = {adc_measure_trig, sw_pc_ctl, azmux, led0, monitor, chan, hi_phase};

  always @(negedge clk) begin
    if (exp_on) begin
      n_checks++;
      if (got_o !== exp_o) begin
        n_errors++;
        $display("FAIL outputs cyc=%0d got trig=%b sw=%b az=%h led=%b mon=%b chan=%0d hi=%b required trig=%b sw=%b az=%h led=%b mon=%b chan=%0d hi=%b",
                 cyc, got_o.trig, got_o.sw, got_o.az, got_o.led, got_o.mon, got_o.chan, got_o.hi,
                 exp_o.trig, exp_o.sw, exp_o.az, exp_o.led, exp_o.mon, exp_o.chan, exp_o.hi);
      end
    end
    if (obs_on && adc_measure_trig) begin
      trig_cyc.push_back(cyc);
      trig_az.push_back(azmux);
    end
  end

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic outs_t mk(input logic trig, input logic mon1);
    outs_t o;
    o.trig = trig;
    o.sw   = m_sw;
    o.az   = m_az;
    o.led  = m_led;
    o.mon  = {mon1, m_mon0};
    o.chan = m_chan[0];
    o.hi   = m_hi;
    return o;
  endfunction

  task automatic lit(input string name, input int got, input int req);
    n_checks++;
    if (got != req) begin
      n_errors++;
      $display("FAIL %s got=%0d required=%0d", name, got, req);
    end
  endtask

  // One clock period of the model: outputs expected after this edge, fresh don't-care inputs.
  task automatic tick(input logic trig, input logic mon1, input logic vld);
    @(posedge clk); #1;
    exp_o             = mk(trig, mon1);
    adc_measure_valid = vld;
    az_mode           = rb();
    precharge_n       = CNT_W'($urandom_range(0, 7));
    settle_n          = CNT_W'($urandom_range(0, 7));
  endtask

  task automatic reset_model();
    m_sw = 1'b0; m_az = 4'h0; m_led = 1'b0; m_hi = 1'b0; m_chan = 0; m_mon0 = 1'b0;
    exp_o  = mk(1'b0, 1'b0);
    exp_on = 1;
  endtask

  task automatic do_reset();
    #2;
    reset = 1'b1;
    reset_model();
    repeat ($urandom_range(1, 3)) begin
      @(posedge clk); #1;
      adc_measure_valid = rb();
    end
    reset = 1'b0;
    d0 = cyc;
  endtask

  task automatic dwell_pc();
    int n;
    n = dir ? 3 : $urandom_range(0, 4);
    precharge_n = CNT_W'(n);
    repeat (n + 1) tick(1'b0, 1'b0, rb());
  endtask

`ifdef SAMPLE_MODULATION_AZSEQ_SETTLE_EN
  task automatic dwell_settle();
    int n;
    n = dir ? 9 : $urandom_range(0, 4);
    settle_n = CNT_W'(n);
    repeat (n + 1) tick(1'b0, 1'b0, rb());
  endtask
`endif

  // Conversion: first cycle ignores valid; ends on the first valid after that.
  task automatic adc_phase(input logic fin_az, input bit abort_here);
    int len;
    len = dir ? 5 : $urandom_range(2, 6);
    for (int j = 0; j < len; j++) begin
      tick(1'b0, 1'b0, (j == 0) ? (dir ? 1'b1 : rb()) : (j == len - 1));
      if (j == len - 1) az_mode = fin_az;
      if (abort_here && j == 1) begin
        aborted = 1;
        return;
      end
    end
  endtask

  task automatic run(input int ntx, input bit abort_en);
    logic mode;
    aborted = 0;
    do_reset();
    tick(1'b0, 1'b0, rb());
    dwell_pc();
    for (int t = 0; t < ntx; t++) begin
      m_az = azmux_hi_vals[m_chan*4 +: 4];
      tick(1'b0, 1'b0, rb());
      dwell_pc();
      m_sw = 1'b1; m_led = 1'b1; m_hi = 1'b1;
      tick(1'b1, 1'b1, dir ? 1'b1 : rb());
      mode = dir ? 1'b1 : rb();
      adc_phase(mode, abort_en && (t == ntx - 1));
      if (aborted) return;
      if (mode) begin
        m_sw = 1'b0;
        tick(1'b0, 1'b0, rb());
        dwell_pc();
        m_az = azmux_lo_val; m_led = 1'b0; m_hi = 1'b0;
        tick(1'b0, 1'b0, rb());
`ifdef SAMPLE_MODULATION_AZSEQ_SETTLE_EN
        dwell_settle();
`endif
        tick(1'b1, 1'b0, rb());
        adc_phase(rb(), 1'b0);
      end
      if (m_chan == NCH - 1) begin
        m_chan = 0;
        m_mon0 = ~m_mon0;
      end else begin
        m_chan++;
      end
    end
  endtask

  initial begin
    int lo_gap;
    @(posedge clk); #1;

    dir = 1; obs_on = 1;
    azmux_hi_vals = 8'h52;
    azmux_lo_val  = 4'hA;
    run(3, 1'b0);
    obs_on = 0; dir = 0;

`ifdef SAMPLE_MODULATION_AZSEQ_SETTLE_EN
    lo_gap = 22;
`else
    lo_gap = 12;
`endif
    lit("trig_count_ge5", int'(trig_cyc.size() >= 5), 1);
    if (trig_cyc.size() >= 5) begin
      lit("first_trig_latency", trig_cyc[0] - d0, 11);
      lit("hi_to_lo_trig_gap", trig_cyc[1] - trig_cyc[0], lo_gap);
      lit("lo_to_hi_trig_gap", trig_cyc[2] - trig_cyc[1], 11);
      lit("azmux_trig0_hi0", int'(trig_az[0]), 2);
      lit("azmux_trig1_lo", int'(trig_az[1]), 10);
      lit("azmux_trig2_hi1", int'(trig_az[2]), 5);
      lit("azmux_trig3_lo", int'(trig_az[3]), 10);
      lit("azmux_trig4_hi0", int'(trig_az[4]), 2);
    end

    for (int r = 0; r < 40; r++) begin
      azmux_hi_vals = 8'($urandom);
      azmux_lo_val  = 4'($urandom);
      run($urandom_range(1, 6), (r % 3) == 1);
    end

    #2;
    reset = 1'b1;
    reset_model();
    repeat (2) @(posedge clk);
    #1;
    exp_on = 0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
